booth_seq_multiplier: RTL and testbench

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

---
 rtl/booth_pkg.sv | 21 ++
 rtl/n_bit_adder_sub.sv | 24 ++
 rtl/booth_seq_multiplier.sv | 141 ++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth sequential multiplier.
package booth_pkg;

    localparam int unsigned BOOTH_DEFAULT_N = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } booth_state_e;

    // Booth recoding of {Q[0], q_m1}: 01 adds M, 10 subtracts M, 00/11 keep A.
    function automatic logic booth_needs_op(input logic q0, input logic q_m1);
        return q0 ^ q_m1;
    endfunction

    function automatic logic booth_is_sub(input logic q0, input logic q_m1);
        return q0 & ~q_m1;
    endfunction

endpackage

// File: rtl/n_bit_adder_sub.sv
// Ripple-style n-bit adder/subtractor: s = a + b when c_in=0, a - b when c_in=1.
module n_bit_adder_sub #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         c_in,
    output logic [n-1:0] s,
    output logic         c_out,
    output logic         overflow
);

    logic [n-1:0] b_eff;
    logic [n:0]   sum_full;

    // Subtraction as a + ~b + 1
    assign b_eff    = b ^ {n{c_in}};
    assign sum_full = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, c_in};

    assign s        = sum_full[n-1:0];
    assign c_out    = sum_full[n];
    assign overflow = (a[n-1] == b_eff[n-1]) && (s[n-1] != a[n-1]);

endmodule

// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth sequential signed multiplier, one partial product per CALC cycle.
// Optional BOOTH_START_ERR_EN adds a start_err pulse for starts issued while busy.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned N = BOOTH_DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
`ifdef BOOTH_START_ERR_EN
    output logic           start_err,
`endif
    output logic [2*N-1:0] product
);

    localparam int unsigned AW = N + 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = 2 * N;

    booth_state_e  state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic          q_m1_q, q_m1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_d;
    logic          done_d;
    logic [PW-1:0] product_d;
`ifdef BOOTH_START_ERR_EN
    logic          start_err_d;
`endif

    logic [AW-1:0] mcand_ext;
    logic [AW-1:0] addsub_sum;
    logic [AW-1:0] acc_sel;
    logic          addsub_sub;
    logic          addsub_c_out_unused;
    logic          addsub_ovf_unused;

    // Sign-extended M keeps A-M in range even for M = -2^(N-1)
    assign mcand_ext  = {mcand_q[N-1], mcand_q};
    assign addsub_sub = booth_is_sub(mplier_q[0], q_m1_q);

    n_bit_adder_sub #(
        .n (AW)
    ) u_addsub (
        .a        (acc_q),
        .b        (mcand_ext),
        .c_in     (addsub_sub),
        .s        (addsub_sum),
        .c_out    (addsub_c_out_unused),
        .overflow (addsub_ovf_unused)
    );

    assign acc_sel = booth_needs_op(mplier_q[0], q_m1_q) ? addsub_sum : acc_q;

    // State register and all datapath/output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            q_m1_q    <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
`ifdef BOOTH_START_ERR_EN
            start_err <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            q_m1_q    <= q_m1_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            product   <= product_d;
`ifdef BOOTH_START_ERR_EN
            start_err <= start_err_d;
`endif
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        q_m1_d    = q_m1_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CALC;
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    acc_d    = '0;
                    q_m1_d   = 1'b0;
                    cnt_d    = CW'(N);
                end
            end
            ST_CALC: begin
                // Arithmetic right shift of {A, Q, q_m1} after the Booth step
                acc_d    = {acc_sel[AW-1], acc_sel[AW-1:1]};
                mplier_d = {acc_sel[0], mplier_q[N-1:1]};
                q_m1_d   = mplier_q[0];
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                product_d = {acc_q[N-1:0], mplier_q};
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
`ifdef BOOTH_START_ERR_EN
        start_err_d = start && (state_q != ST_IDLE);
`endif
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (N=8 with a cycle model, N=32 sweep).
// Build with BOOTH_START_ERR_EN defined to also check start_err.
module tb_booth_seq_multiplier;

    localparam int unsigned N8  = 8;
    localparam int unsigned N32 = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        start8  = 1'b0;
    logic [7:0]  mc8     = '0;
    logic [7:0]  mq8     = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    logic        start32 = 1'b0;
    logic [31:0] mc32    = '0;
    logic [31:0] mq32    = '0;
    logic        busy32;
    logic        done32;
    logic [63:0] product32;

`ifdef BOOTH_START_ERR_EN
    logic        err8;
    logic        err32;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_seq_multiplier #(.N(N8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .multiplicand (mc8),
        .multiplier   (mq8),
        .busy         (busy8),
        .done         (done8),
`ifdef BOOTH_START_ERR_EN
        .start_err    (err8),
`endif
        .product      (product8)
    );

    booth_seq_multiplier #(.N(N32)) dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start32),
        .multiplicand (mc32),
        .multiplier   (mq32),
        .busy         (busy32),
        .done         (done32),
`ifdef BOOTH_START_ERR_EN
        .start_err    (err32),
`endif
        .product      (product32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q);
        logic signed [15:0] a;
        logic signed [15:0] b;
        a = {{8{m[7]}}, m};
        b = {{8{q[7]}}, q};
        return 16'(a * b);
    endfunction

    function automatic logic [63:0] ref32(input logic [31:0] m, input logic [31:0] q);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = {{32{m[31]}}, m};
        b = {{32{q[31]}}, q};
        return a * b;
    endfunction

    // Transaction-level model of the N=8 instance: countdown to done, product held
    int          rem8      = 0;
    logic [15:0] pend8     = '0;
    logic [15:0] exp_prod8 = '0;
    logic        exp_done8 = 1'b0;
    logic        exp_err8  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem8      <= 0;
            pend8     <= '0;
            exp_prod8 <= '0;
            exp_done8 <= 1'b0;
            exp_err8  <= 1'b0;
        end else begin
            exp_err8  <= start8 && (rem8 != 0);
            exp_done8 <= (rem8 == 1);
            if (rem8 == 0) begin
                if (start8) begin
                    pend8 <= ref8(mc8, mq8);
                    rem8  <= int'(N8) + 1;
                end
            end else begin
                rem8 <= rem8 - 1;
                if (rem8 == 1) exp_prod8 <= pend8;
            end
        end
    end

    always @(negedge clk) begin
        check("busy8",    64'(busy8),    64'(rem8 != 0));
        check("done8",    64'(done8),    64'(exp_done8));
        check("product8", 64'(product8), 64'(exp_prod8));
`ifdef BOOTH_START_ERR_EN
        check("start_err8", 64'(err8), 64'(exp_err8));
`endif
    end

    // Entered at a negedge; returns at the negedge where done is seen
    task automatic mult8(input logic [7:0] m, input logic [7:0] q, input string name);
        int cyc;
        logic [15:0] want;
        want   = ref8(m, q);
        start8 = 1'b1;
        mc8    = m;
        mq8    = q;
        @(negedge clk);
        start8 = 1'b0;
        mc8    = 8'($urandom);
        mq8    = 8'($urandom);
        cyc    = 1;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(N8 + 2));
        check({name, "_product"}, 64'(product8), 64'(want));
    endtask

    task automatic mult32(input logic [31:0] m, input logic [31:0] q, input string name);
        int cyc;
        logic [63:0] want;
        want    = ref32(m, q);
        start32 = 1'b1;
        mc32    = m;
        mq32    = q;
        @(negedge clk);
        start32 = 1'b0;
        mc32    = $urandom;
        mq32    = $urandom;
        cyc     = 1;
        while (!done32 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency32"}, 64'(cyc), 64'(N32 + 2));
        check({name, "_product32"}, product32, want);
    endtask

    initial begin
        int n_done;
        int n_perr;

        rst_n = 1'b0;
        #1;
        check("rst_busy8",     64'(busy8),    64'(0));
        check("rst_done8",     64'(done8),    64'(0));
        check("rst_product8",  64'(product8), 64'(0));
        check("rst_product32", product32,     64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First start right after reset release, then literal anchors for the model
        mult8(8'd3, 8'hFC, "m3_qm4");
        check("lit_m3_qm4", 64'(product8), 64'h0000_0000_0000_FFF4);
        @(negedge clk);
        mult8(8'h80, 8'h80, "mmin_qmin");
        check("lit_mmin_qmin", 64'(product8), 64'h0000_0000_0000_4000);
        @(negedge clk);
        mult8(8'h7F, 8'h80, "mmax_qmin");
        check("lit_mmax_qmin", 64'(product8), 64'h0000_0000_0000_C080);
        @(negedge clk);
        mult8(8'h00, 8'hFF, "m0_qm1");
        check("lit_m0_qm1", 64'(product8), 64'h0);

        // Product must hold through idle cycles
        repeat (5) @(negedge clk);

        // Start pulsed on CALC cycle 3 is ignored
        start8 = 1'b1;
        mc8    = 8'd5;
        mq8    = 8'hF9;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1;
        mc8    = 8'h7F;
        mq8    = 8'h7F;
        n_done = 0;
        n_perr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) start8 = 1'b0;
            n_done += int'(done8);
`ifdef BOOTH_START_ERR_EN
            n_perr += int'(err8);
`endif
        end
        check("midstart_done_count", 64'(n_done), 64'(1));
        check("lit_midstart_product", 64'(product8), 64'h0000_0000_0000_FFDD);
`ifdef BOOTH_START_ERR_EN
        check("midstart_err_count", 64'(n_perr), 64'(1));
`else
        check("midstart_err_count", 64'(n_perr), 64'(0));
`endif

        // Reset during CALC cycle 4 abandons the operation
        start8 = 1'b1;
        mc8    = 8'd9;
        mq8    = 8'd11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy8",    64'(busy8),    64'(0));
        check("midrst_done8",    64'(done8),    64'(0));
        check("midrst_product8", 64'(product8), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            n_done += int'(done8);
        end
        check("midrst_no_done", 64'(n_done), 64'(0));
        mult8(8'd9, 8'd11, "after_rst");
        check("lit_after_rst", 64'(product8), 64'h0000_0000_0000_0063);

        // Back-to-back: second start issued in the done cycle
        @(negedge clk);
        mult8(8'hF6, 8'd7,  "b2b_a");
        mult8(8'd12, 8'hF3, "b2b_b");
        mult8(8'h81, 8'h81, "b2b_c");
        repeat (3) @(negedge clk);

        // N=32 directed corners and random sweep
        mult32(32'h8000_0000, 32'h8000_0000, "w_min_min");
        check("lit_w_min_min", product32, 64'h4000_0000_0000_0000);
        mult32(32'hFFFF_FFFF, 32'h7FFF_FFFF, "w_m1_max");
        check("lit_w_m1_max", product32, 64'hFFFF_FFFF_8000_0001);
        for (int i = 0; i < 1000; i++) begin
            mult32($urandom, $urandom, "w_rand");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
